// File: rtl/cmos_pixel_packer_if.sv
// Packed-word stream between the pixel packer and the frame-buffer write FIFO.
// Valid/ready handshake with frame and line markers qualifying the data.
interface cmos_pixel_packer_if #(
    parameter int DW = 128
) ();
    logic          pack_valid;
    logic          pack_ready;
    logic [DW-1:0] pack_data;
    logic          pack_sof;
    logic          pack_eol;

    modport master (
        output pack_valid,
        output pack_data,
        output pack_sof,
        output pack_eol,
        input  pack_ready
    );

    modport slave (
        input  pack_valid,
        input  pack_data,
        input  pack_sof,
        input  pack_eol,
        output pack_ready
    );
endinterface

// File: rtl/cmos_pixel_packer.sv
// Camera pixel stream to 32-bit-lane packed words, with a small output FIFO,
// frame/line markers, frame timing pulses and a sticky overflow flag.
module cmos_pixel_packer #(
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int IMG_HDISP       = 1280,
    parameter int IMG_VDISP       = 720,
    parameter bit VSYNC_POL       = 1'b1,
    parameter int OUT_DEPTH       = 4
) (
    input  logic                       cmos_clk,
    input  logic                       rst_n,
    input  logic                       cmos_vsync,
    input  logic                       cmos_href,
    input  logic                       cmos_clken,
    input  logic [23:0]                cmos_data,
    cmos_pixel_packer_if.master        pack,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       overflow,
    output logic [10:0]                line_cnt
);
    localparam int PPW = AXI4_DATA_WIDTH / 32;
    localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int AW  = $clog2(OUT_DEPTH);
    localparam int EW  = AXI4_DATA_WIDTH + 2;
    localparam logic [10:0]   HD        = 11'(IMG_HDISP);
    localparam logic [10:0]   VD        = 11'(IMG_VDISP);
    localparam logic [LW-1:0] LAST_LANE = LW'(PPW - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(OUT_DEPTH);

    logic                       r_vs_d;
    logic                       r_href_d;
    logic [LW-1:0]              r_lane;
    logic [10:0]                r_pix_cnt;
    logic [10:0]                r_line_cnt;
    logic [AXI4_DATA_WIDTH-1:0] r_word;
    logic                       r_sof_arm;
    logic                       r_frame_start;
    logic                       r_frame_done;
    logic                       r_overflow;
    logic [EW-1:0]              r_mem [OUT_DEPTH];
    logic [AW:0]                r_wr_ptr;
    logic [AW:0]                r_rd_ptr;

    logic                       w_vs_act;
    logic                       w_vs_edge;
    logic                       w_href_fall;
    logic                       w_accept;
    logic                       w_last_pix;
    logic                       w_full_lane;
    logic                       w_flush;
    logic                       w_line_end;
    logic                       w_complete;
    logic                       w_eol;
    logic                       w_push;
    logic [AW:0]                w_count;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_wr_en;
    logic                       w_drop;
    logic [AXI4_DATA_WIDTH-1:0] w_word;
    logic [EW-1:0]              w_head;

    assign w_vs_act    = (cmos_vsync == VSYNC_POL);
    assign w_vs_edge   = w_vs_act & ~r_vs_d;
    assign w_href_fall = r_href_d & ~cmos_href;
    assign w_accept    = cmos_href & cmos_clken
                       & (r_pix_cnt < HD) & (r_line_cnt < VD);
    assign w_last_pix  = (r_pix_cnt == HD - 11'd1);
    assign w_full_lane = (r_lane == LAST_LANE);
    assign w_flush     = w_href_fall & (r_lane != '0);
    assign w_line_end  = w_href_fall & (r_pix_cnt != '0);
    assign w_complete  = (w_accept & (w_full_lane | w_last_pix)) | w_flush;
    assign w_eol       = w_flush | (w_accept & w_last_pix);
    // A vsync edge in the same cycle discards the word instead of pushing it
    assign w_push      = w_complete & ~w_vs_edge;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_count == FULL_CNT);
    assign w_pop   = ~w_empty & pack.pack_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_comb begin
        w_word = r_word;
        if (w_accept) begin
            for (int k = 0; k < PPW; k++) begin
                if (r_lane == LW'(k)) begin
                    w_word[32*k +: 32] = {8'h00, cmos_data};
                end
            end
        end
    end

    always_ff @(posedge cmos_clk) begin
        if (!rst_n) begin
            r_vs_d        <= 1'b0;
            r_href_d      <= 1'b0;
            r_lane        <= '0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_word        <= '0;
            r_sof_arm     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_vs_d        <= w_vs_act;
            r_href_d      <= cmos_href;
            r_frame_start <= w_vs_edge;
            r_frame_done  <= w_line_end & ~w_vs_edge
                           & (r_line_cnt == VD - 11'd1);
            if (w_vs_edge) begin
                r_lane     <= '0;
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_word     <= '0;
                r_sof_arm  <= 1'b1;
                r_overflow <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_pix_cnt <= r_pix_cnt + 11'd1;
                    if (w_complete) begin
                        r_lane <= '0;
                        r_word <= '0;
                    end else begin
                        r_lane <= r_lane + LW'(1);
                        r_word <= w_word;
                    end
                end
                if (w_line_end) begin
                    r_line_cnt <= r_line_cnt + 11'd1;
                    r_pix_cnt  <= '0;
                    r_lane     <= '0;
                end
                if (w_flush) begin
                    r_word <= '0;
                end
                if (w_wr_en) begin
                    r_sof_arm <= 1'b0;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge cmos_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {r_sof_arm, w_eol, w_word};
        end
    end

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    assign pack.pack_valid = ~w_empty;
    assign pack.pack_sof   = ~w_empty & w_head[EW-1];
    assign pack.pack_eol   = ~w_empty & w_head[EW-2];
    assign pack.pack_data  = w_empty ? '0 : w_head[AXI4_DATA_WIDTH-1:0];

    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign line_cnt    = r_line_cnt;
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed + randomized bench for cmos_pixel_packer (8x2 frame, 4 lanes).
// Expected words come from a line-level model that chunks accepted pixels.
module tb_cmos_pixel_packer;
    localparam int HD  = 8;
    localparam int VD  = 2;
    localparam int DW  = 128;
    localparam int PPW = DW / 32;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic [DW-1:0] data;
    } wrd_t;
    typedef logic [23:0] pq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        clken = 1'b0;
    logic [23:0] data = '0;
    logic        frame_start;
    logic        frame_done;
    logic        overflow;
    logic [10:0] line_cnt;

    cmos_pixel_packer_if #(.DW(DW)) pk ();

    cmos_pixel_packer #(
        .AXI4_DATA_WIDTH(DW),
        .IMG_HDISP(HD),
        .IMG_VDISP(VD),
        .VSYNC_POL(1'b1),
        .OUT_DEPTH(4)
    ) dut (
        .cmos_clk(clk),
        .rst_n(rst_n),
        .cmos_vsync(vsync),
        .cmos_href(href),
        .cmos_clken(clken),
        .cmos_data(data),
        .pack(pk),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .overflow(overflow),
        .line_cnt(line_cnt)
    );

    always #5 clk = ~clk;

    wrd_t exp_q[$];
    wrd_t act_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fs_cnt = 0;
    int   fd_cnt = 0;
    int   exp_fs = 0;
    int   exp_fd = 0;
    int   m_lines = 0;
    bit   m_sof = 1'b0;
    int   pn = 0;
    bit   rnd_rdy = 1'b0;
    bit   hold = 1'b0;
    wrd_t hold_w;
    wrd_t mon_w;

    // Transfers, pulse counts and hold-stability, sampled mid-cycle
    always @(negedge clk) begin
        mon_w = {pk.pack_sof, pk.pack_eol, pk.pack_data};
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                assert (pk.pack_valid === 1'b1 && mon_w === hold_w) else begin
                    errors++;
                    $error("FAIL stable: valid=%b word=%h required %h",
                           pk.pack_valid, mon_w, hold_w);
                end
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
            if (pk.pack_valid && pk.pack_ready) act_q.push_back(mon_w);
            hold = pk.pack_valid && !pk.pack_ready;
            hold_w = mon_w;
        end
    end

    task automatic chk(input string tag, input logic [DW+1:0] got,
                       input logic [DW+1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) pk.pack_ready = ($urandom_range(9, 0) < 7);
        end
    endtask

    task automatic model_frame();
        exp_fs++;
        m_lines = 0;
        m_sof = 1'b1;
        pn = 0;
    endtask

    // A line yields ceil(n/PPW) words of its first min(n,HD) pixels
    task automatic model_line(input pq_t lq, input bit drop);
        int   n;
        int   c;
        wrd_t w;
        if (m_lines >= VD || lq.size() == 0) return;
        n = (lq.size() < HD) ? lq.size() : HD;
        for (int i = 0; i < n; i += PPW) begin
            c = (n - i < PPW) ? n - i : PPW;
            w = '0;
            w.sof = m_sof;
            w.eol = (i + c == HD) || (c < PPW);
            for (int k = 0; k < c; k++) w.data[32*k +: 32] = {8'h00, lq[i+k]};
            if (!drop) begin
                exp_q.push_back(w);
                m_sof = 1'b0;
            end
        end
        m_lines++;
        if (m_lines == VD) exp_fd++;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick(3);
        model_frame();
    endtask

    task automatic drive_line(input int npix, input int duty, input bit drop);
        pq_t lq;
        int  got = 0;
        href = 1'b1;
        while (got < npix) begin
            clken = ($urandom_range(99, 0) < duty);
            if (clken) begin
                pn++;
                data = 24'(pn);
                lq.push_back(data);
                got++;
            end else begin
                data = 24'($urandom);
            end
            tick();
        end
        clken = 1'b0;
        href = 1'b0;
        data = '0;
        tick(4);
        model_line(lq, drop);
    endtask

    task automatic drain_cmp(input string tag);
        int t = 0;
        while ((pk.pack_valid || act_q.size() < exp_q.size()) && t < 300) begin
            tick();
            t++;
        end
        chk({tag, "_timeout"}, (t < 300), 1'b1);
        chk({tag, "_nwords"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), act_q[i], exp_q[i]);
        end
        chk({tag, "_fstart"}, fs_cnt, exp_fs);
        chk({tag, "_fdone"}, fd_cnt, exp_fd);
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        wrd_t w0;
        wrd_t w1;
        w0 = {1'b1, 1'b0, 128'h00000004_00000003_00000002_00000001};
        w1 = {1'b0, 1'b1, 128'h00000000_00000000_00000006_00000005};
        pk.pack_ready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_valid", pk.pack_valid, 1'b0);
        chk("rst_data", {pk.pack_sof, pk.pack_eol, pk.pack_data}, '0);
        chk("rst_line", line_cnt, 11'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_pulses", {frame_start, frame_done}, 2'b00);
        rst_n = 1'b1;
        tick(2);

        // Full 8x2 frame, always ready
        pk.pack_ready = 1'b1;
        vs_pulse();
        drive_line(8, 100, 1'b0);
        drive_line(8, 100, 1'b0);
        tick(6);
        chk("t1_word0", act_q[0], w0);
        chk("t1_line", line_cnt, 11'd2);
        drain_cmp("t1");

        // Same frame with ~50% clken
        vs_pulse();
        drive_line(8, 50, 1'b0);
        drive_line(8, 50, 1'b0);
        chk("t2_line", line_cnt, 11'd2);
        drain_cmp("t2");

        // Backpressure: fill the FIFO, then overflow on the next frame
        pk.pack_ready = 1'b0;
        vs_pulse();
        drive_line(8, 100, 1'b0);
        drive_line(8, 100, 1'b0);
        tick(5);
        chk("t3_valid", pk.pack_valid, 1'b1);
        chk("t3_head", {pk.pack_sof, pk.pack_eol, pk.pack_data}, w0);
        chk("t3_ovf0", overflow, 1'b0);
        vs_pulse();
        drive_line(8, 100, 1'b1);
        drive_line(8, 100, 1'b1);
        chk("t3_ovf1", overflow, 1'b1);
        tick(10);
        chk("t3_ovf_sticky", overflow, 1'b1);
        vs_pulse();
        chk("t3_ovf_clr", overflow, 1'b0);
        pk.pack_ready = 1'b1;
        drain_cmp("t3");

        // Short first line (6 pixels)
        vs_pulse();
        drive_line(6, 100, 1'b0);
        tick(4);
        chk("t4_line", line_cnt, 11'd1);
        chk("t4_word1", act_q[1], w1);
        drive_line(8, 100, 1'b0);
        drain_cmp("t4");

        // Vsync edge in the middle of a line discards the partial word
        vs_pulse();
        href = 1'b1;
        clken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data = 24'(i + 1);
            tick();
        end
        clken = 1'b0;
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        href = 1'b0;
        model_frame();
        tick(4);
        chk("t5_novalid", pk.pack_valid, 1'b0);
        chk("t5_noword", act_q.size(), 0);
        chk("t5_line", line_cnt, 11'd0);
        chk("t5_fstart", fs_cnt, exp_fs);
        drive_line(8, 100, 1'b0);
        drive_line(8, 100, 1'b0);
        drain_cmp("t5");

        // Reset mid-line with two words queued
        pk.pack_ready = 1'b0;
        vs_pulse();
        drive_line(8, 100, 1'b0);
        href = 1'b1;
        clken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 24'(100 + i);
            tick();
        end
        chk("t6_pre_valid", pk.pack_valid, 1'b1);
        rst_n = 1'b0;
        href = 1'b0;
        clken = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_valid", pk.pack_valid, 1'b0);
        chk("t6_line", line_cnt, 11'd0);
        chk("t6_ovf", overflow, 1'b0);
        exp_q.delete();
        act_q.delete();
        m_lines = 0;
        pk.pack_ready = 1'b1;
        tick(2);
        vs_pulse();
        drive_line(8, 50, 1'b0);
        drive_line(8, 50, 1'b0);
        drain_cmp("t6");

        // Random frames: line lengths incl. short/excess, extra lines, random ready
        for (int f = 0; f < 6; f++) begin
            rnd_rdy = 1'b1;
            vs_pulse();
            for (int l = 0; l < int'($urandom_range(3, 1)); l++) begin
                drive_line(int'($urandom_range(11, 1)),
                           int'($urandom_range(100, 40)), 1'b0);
            end
            rnd_rdy = 1'b0;
            pk.pack_ready = 1'b1;
            chk($sformatf("rnd%0d_line", f), line_cnt, 11'(m_lines));
            drain_cmp($sformatf("rnd%0d", f));
            chk($sformatf("rnd%0d_ovf", f), overflow, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
